sample_iterator: RTL and testbench

Walks the subsample grid inside a triangle's screen-space bounding box, one sample location per cycle. Drives the sample test stage with the triangle, its colour, the current sample position and a sample-valid flag. Sits between bounding-box generation, which is upstream, and the sample test, which is downstream. Upstream flow control uses a halt signal; the downstream side has no backpressure.

---
 rtl/sample_iterator.sv | 137 +++++++++++++
 tb/tb_sample_iterator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_iterator.sv
// rtl/sample_iterator.sv - walks the subsample grid of a triangle bounding box, one sample per cycle
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
    input  logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
    input  logic [1:0][1:0][SIGFIG-1:0]              box_R14S,
    input  logic                                     validTri_R14H,
    input  logic [3:0]                               ss_w_lg2_R14S,
    output logic                                     halt_RnnnnL,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R16S,
    output logic [COLORS-1:0][SIGFIG-1:0]            color_R16U,
    output logic [1:0][SIGFIG-1:0]                   sample_R16S,
    output logic                                     validSamp_R16H
);

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_TEST = 1'b1;

    logic [0:0]                             state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic signed [SIGFIG-1:0]               ll_x_q, ll_x_d;
    logic signed [SIGFIG-1:0]               ur_x_q, ur_x_d;
    logic signed [SIGFIG-1:0]               ur_y_q, ur_y_d;
    logic signed [SIGFIG-1:0]               x_q, x_d;
    logic signed [SIGFIG-1:0]               y_q, y_d;
    logic [SIGFIG-1:0]                      step_q, step_d;
    logic                                   valid_q, valid_d;

    logic signed [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y;
    logic                     box_ok;
    logic [1:0]               ss_eff;
    logic [SIGFIG-1:0]        in_step;
    logic signed [SIGFIG:0]   nx, ny;
    logic                     nx_ok, ny_ok;

    // Decode the incoming box/step and form the one-bit-wider next positions so a
    // step past the positive limit compares as beyond the box instead of wrapping.
    always_comb begin
        in_ll_x = $signed(box_R14S[0][0]);
        in_ll_y = $signed(box_R14S[0][1]);
        in_ur_x = $signed(box_R14S[1][0]);
        in_ur_y = $signed(box_R14S[1][1]);
        box_ok  = (in_ll_x <= in_ur_x) && (in_ll_y <= in_ur_y);
        ss_eff  = (ss_w_lg2_R14S > 4'd3) ? 2'd3 : ss_w_lg2_R14S[1:0];
        in_step = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(ss_eff));
        nx      = $signed({x_q[SIGFIG-1], x_q}) + $signed({1'b0, step_q});
        ny      = $signed({y_q[SIGFIG-1], y_q}) + $signed({1'b0, step_q});
        nx_ok   = nx <= $signed({ur_x_q[SIGFIG-1], ur_x_q});
        ny_ok   = ny <= $signed({ur_y_q[SIGFIG-1], ur_y_q});
    end

    // Next-state: accept a non-empty box in WAIT, then scan x-major until the top-right corner.
    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        ll_x_d  = ll_x_q;
        ur_x_d  = ur_x_q;
        ur_y_d  = ur_y_q;
        x_d     = x_q;
        y_d     = y_q;
        step_d  = step_q;
        valid_d = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (validTri_R14H && box_ok) begin
                    tri_d   = tri_R14S;
                    color_d = color_R14U;
                    ll_x_d  = in_ll_x;
                    ur_x_d  = in_ur_x;
                    ur_y_d  = in_ur_y;
                    step_d  = in_step;
                    x_d     = in_ll_x;
                    y_d     = in_ll_y;
                    valid_d = 1'b1;
                    state_d = ST_TEST;
                end
            end
            ST_TEST: begin
                valid_d = 1'b1;
                if (nx_ok) begin
                    x_d = nx[SIGFIG-1:0];
                end else if (ny_ok) begin
                    x_d = ll_x_q;
                    y_d = ny[SIGFIG-1:0];
                end else begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // State and output registers; reset discards any partial triangle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_WAIT;
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            step_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            ll_x_q  <= ll_x_d;
            ur_x_q  <= ur_x_d;
            ur_y_q  <= ur_y_d;
            x_q     <= x_d;
            y_q     <= y_d;
            step_q  <= step_d;
            valid_q <= valid_d;
        end
    end

    assign halt_RnnnnL    = (state_q == ST_WAIT);
    assign tri_R16S       = tri_q;
    assign color_R16U     = color_q;
    assign sample_R16S[0] = x_q;
    assign sample_R16S[1] = y_q;
    assign validSamp_R16H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// tb/tb_sample_iterator.sv - directed and randomized bench for sample_iterator
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic                                   clk = 1'b0;
    logic                                   rst = 1'b0;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S = '0;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U = '0;
    logic [1:0][1:0][SIGFIG-1:0]            box_R14S = '0;
    logic                                   validTri_R14H = 1'b0;
    logic [3:0]                             ss_w_lg2_R14S = '0;
    logic                                   halt_RnnnnL;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R16U;
    logic [1:0][SIGFIG-1:0]                 sample_R16S;
    logic                                   validSamp_R16H;

    int tests = 0;
    int fails = 0;

    longint exp_x[$], exp_y[$], got_x[$], got_y[$];

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_a, tri_b;
    logic [COLORS-1:0][SIGFIG-1:0]          col_a, col_b;
    bit                                     quiet;

    always #5 clk = ~clk;

    sample_iterator dut (
        .clk            (clk),
        .rst            (rst),
        .tri_R14S       (tri_R14S),
        .color_R14U     (color_R14U),
        .box_R14S       (box_R14S),
        .validTri_R14H  (validTri_R14H),
        .ss_w_lg2_R14S  (ss_w_lg2_R14S),
        .halt_RnnnnL    (halt_RnnnnL),
        .tri_R16S       (tri_R16S),
        .color_R16U     (color_R16U),
        .sample_R16S    (sample_R16S),
        .validSamp_R16H (validSamp_R16H)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint samp_x();
        return longint'($signed(sample_R16S[0]));
    endfunction

    function automatic longint samp_y();
        return longint'($signed(sample_R16S[1]));
    endfunction

    // Reference: every grid point ll + k*step inside the box, row by row from the bottom.
    task automatic build_model(input longint llx, input longint lly, input longint urx,
                               input longint ury, input int ss);
        longint st;
        exp_x.delete();
        exp_y.delete();
        st = longint'(1) << (10 - ((ss > 3) ? 3 : ss));
        for (longint y = lly; y <= ury; y += st)
            for (longint x = llx; x <= urx; x += st) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endtask

    // Present a triangle with random payload and the given box; validTri stays high.
    task automatic load(input longint llx, input longint lly, input longint urx,
                        input longint ury, input int ss);
        for (int i = 0; i < VERTS; i++)
            for (int j = 0; j < AXIS; j++)
                tri_R14S[i][j] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_R14U[c] = SIGFIG'($urandom);
        box_R14S[0][0] = SIGFIG'(llx);
        box_R14S[0][1] = SIGFIG'(lly);
        box_R14S[1][0] = SIGFIG'(urx);
        box_R14S[1][1] = SIGFIG'(ury);
        ss_w_lg2_R14S  = 4'(ss);
        validTri_R14H  = 1'b1;
    endtask

    // Gather the sample burst starting at the current negedge and compare with the model.
    task automatic collect(input string tag,
                           input logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_e,
                           input logic [COLORS-1:0][SIGFIG-1:0] col_e);
        bit started = 1'b0;
        bit hold_ok = 1'b1;
        bit halt_ok = 1'b1;
        int cyc = 0;
        got_x.delete();
        got_y.delete();
        while (cyc < 2000) begin
            if (validSamp_R16H === 1'b1) begin
                started = 1'b1;
                got_x.push_back(samp_x());
                got_y.push_back(samp_y());
                if (tri_R16S !== tri_e || color_R16U !== col_e) hold_ok = 1'b0;
                if (halt_RnnnnL !== 1'b0) halt_ok = 1'b0;
            end else if (started) begin
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_in_budget"}, longint'(cyc < 2000), 1);
        chk({tag, "_count"}, got_x.size(), exp_x.size());
        for (int k = 0; k < got_x.size() && k < exp_x.size(); k++) begin
            chk($sformatf("%s_x%0d", tag, k), got_x[k], exp_x[k]);
            chk($sformatf("%s_y%0d", tag, k), got_y[k], exp_y[k]);
        end
        chk({tag, "_tri_color_hold"}, longint'(hold_ok), 1);
        chk({tag, "_halt_low_busy"}, longint'(halt_ok), 1);
        chk({tag, "_halt_after"}, longint'(halt_RnnnnL), 1);
        chk({tag, "_valid_after"}, longint'(validSamp_R16H), 0);
    endtask

    task automatic run_one(input string tag, input longint llx, input longint lly,
                           input longint urx, input longint ury, input int ss);
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t_e;
        logic [COLORS-1:0][SIGFIG-1:0]          c_e;
        @(negedge clk);
        chk({tag, "_ready"}, longint'(halt_RnnnnL), 1);
        load(llx, lly, urx, ury, ss);
        build_model(llx, lly, urx, ury, ss);
        t_e = tri_R14S;
        c_e = color_R14U;
        @(negedge clk);
        validTri_R14H = 1'b0;
        chk({tag, "_first_latency"}, longint'(validSamp_R16H), 1);
        collect(tag, t_e, c_e);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", longint'(validSamp_R16H), 0);
        chk("rst_halt", longint'(halt_RnnnnL), 1);
        chk("rst_sample", longint'(sample_R16S === '0), 1);
        chk("rst_tri_color", longint'((tri_R16S === '0) && (color_R16U === '0)), 1);
        rst = 1'b1;

        // Directed boxes
        run_one("single", 1024, 2048, 1024, 2048, 0);
        run_one("grid2x2", 0, 0, 1024, 1024, 0);
        run_one("ss1", 0, 0, 1024, 0, 1);
        run_one("ss2", 0, 0, 1024, 0, 2);
        run_one("ss3", -1000, 100, 0, 300, 3);
        run_one("ss_clamp", 0, 0, 512, 128, 9);
        // One sample per row: next x overflows the 24-bit positive range
        run_one("edge_wrap1", 8388607 - 1023, 0, 8388607, 1024, 0);
        run_one("edge_wrap2", 8388607 - 1024, 8388607 - 1024, 8388607, 8388607, 0);

        // Empty box is consumed without any sample
        @(negedge clk);
        load(2048, 0, 1024, 0, 0);
        @(negedge clk);
        validTri_R14H = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            if (validSamp_R16H !== 1'b0 || halt_RnnnnL !== 1'b1) quiet = 1'b0;
            @(negedge clk);
        end
        chk("empty_no_sample", longint'(quiet), 1);

        // Back-to-back: second triangle held during the first and accepted in the idle cycle
        @(negedge clk);
        load(0, 0, 1024, 1024, 0);
        build_model(0, 0, 1024, 1024, 0);
        tri_a = tri_R14S;
        col_a = color_R14U;
        @(negedge clk);
        load(-512, 0, 512, 0, 1);
        tri_b = tri_R14S;
        col_b = color_R14U;
        collect("b2b_a", tri_a, col_a);
        chk("b2b_idle_tri", longint'((tri_R16S === tri_a) && (color_R16U === col_a)), 1);
        @(negedge clk);
        validTri_R14H = 1'b0;
        build_model(-512, 0, 512, 0, 1);
        chk("b2b_b_first", longint'(validSamp_R16H), 1);
        collect("b2b_b", tri_b, col_b);

        // Reset during the third sample of a 2x2 box
        @(negedge clk);
        load(0, 0, 1024, 1024, 0);
        @(negedge clk);
        validTri_R14H = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_pre_valid", longint'(validSamp_R16H), 1);
        chk("rstmid_pre_x", samp_x(), 0);
        chk("rstmid_pre_y", samp_y(), 1024);
        rst = 1'b0;
        #1;
        chk("rstmid_valid", longint'(validSamp_R16H), 0);
        chk("rstmid_halt", longint'(halt_RnnnnL), 1);
        @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (validSamp_R16H !== 1'b0 || halt_RnnnnL !== 1'b1) quiet = 1'b0;
        end
        chk("rstmid_no_more", longint'(quiet), 1);
        run_one("after_rst", 2048, -1024, 4096, 0, 1);

        // Randomized boxes and subsample rates
        for (int n = 0; n < 10; n++) begin
            longint llx, lly;
            llx = longint'($urandom_range(0, 8192)) - 4096;
            lly = longint'($urandom_range(0, 8192)) - 4096;
            run_one($sformatf("rnd%0d", n), llx, lly,
                    llx + longint'($urandom_range(0, 2500)),
                    lly + longint'($urandom_range(0, 2500)),
                    int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
